// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive (and later transmit) engines.
//
// Contents:
//   CKW_DEFAULT   default width of the clock divider and bit-period counter
//   CKDIV_MIN     smallest meaningful clocks-per-bit value
//   DATA_BITS_8/9 character widths supported by the deframer
//   uart_state_e  receive state encoding (IDLE, START, DATA, STOP)
//   majority3     2-of-3 vote used when majority sampling is built in
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int CKW_DEFAULT = 24;
    localparam int CKDIV_MIN   = 16;

    localparam logic [3:0] DATA_BITS_8 = 4'd8;
    localparam logic [3:0] DATA_BITS_9 = 4'd9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Two-of-three vote: the bit value held by at least two of the samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Brings an asynchronous, idle-high serial line into the clock domain through
// a chain of STAGES flops and flags the cycle in which the synchronized value
// drops from 1 to 0. Written generically so the TX CTS input can reuse it.
//
// Parameters:
//   STAGES   number of synchronizer flops (2 or more)
//
// Ports:
//   i_clk    system clock
//   i_rstN   synchronous active-low reset; all flops return to the idle level 1
//   i_async  asynchronous line input
//   o_sync   synchronized line value (last flop of the chain)
//   o_fall   high for one cycle when o_sync has just fallen from 1 to 0
// ----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic [STAGES-1:0] r_chain;
    logic              r_prev;

    // The chain and the edge-detect history both reset to the idle level so
    // that releasing reset never manufactures a falling edge on its own.
    // A line that is genuinely low after reset is seen as a fresh edge once
    // it has walked through the chain, which is what the receiver wants.
    always_ff @(posedge i_clk) begin
        if (!i_rstN) begin
            r_chain <= '1;
            r_prev  <= 1'b1;
        end else begin
            r_chain <= {r_chain[STAGES-2:0], i_async};
            r_prev  <= r_chain[STAGES-1];
        end
    end

    assign o_sync = r_chain[STAGES-1];
    assign o_fall = r_prev & ~r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
// UART receive engine feeding the RX byte FIFO of the UART register block.
// Deframes 8- or 9-bit characters with one or two stop bits from the
// asynchronous rxd line, pushes good characters into the FIFO and reports a
// sticky error flag plus a receive-timeout level back to the register block.
//
// Build option:
//   UART_RX_MAJORITY_EN  when defined, every bit decision (start, data, stop)
//                        is the 2-of-3 vote of the synchronized line one clock
//                        before, at and one clock after the mid-bit point; the
//                        decision is then taken one clock after mid-bit.
//                        When undefined, the line is sampled once at mid-bit.
//
// Parameters:
//   CKW          width of ckdiv and of the bit-period counter
//   SYNC_STAGES  number of rxd synchronizer flops (2 or more)
//
// Ports:
//   clk       system clock
//   rst_n     synchronous active-low reset
//   clr_n     0 = clear all internal state exactly like reset (UART disabled)
//   ckdiv     clocks per bit period (16 or more)
//   data9b    1 = 9 data bits, 0 = 8 data bits
//   stop2b    1 = two stop bits checked, 0 = one
//   totime    receive timeout in idle bit periods, 0 = timeout disabled
//   rxd       asynchronous serial input, idle high
//   rf_write  one-cycle push strobe to the RX FIFO
//   rf_wbyte  received character, bit 8 is 0 in 8-bit mode
//   rf_full   RX FIFO full
//   error     sticky framing / overrun flag
//   timeout   receive-timeout level
// ----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CKW         = CKW_DEFAULT,
    parameter int SYNC_STAGES = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr_n,
    input  logic [CKW-1:0] ckdiv,
    input  logic           data9b,
    input  logic           stop2b,
    input  logic [7:0]     totime,
    input  logic           rxd,
    output logic           rf_write,
    output logic [8:0]     rf_wbyte,
    input  logic           rf_full,
    output logic           error,
    output logic           timeout
);

    localparam logic [CKW-1:0] CNT_ONE   = {{(CKW-1){1'b0}}, 1'b1};
    localparam logic [CKW-1:0] DIV_FLOOR = CKW'(CKDIV_MIN);

    uart_state_e    r_state;
    logic [CKW-1:0] r_cnt;
    logic [3:0]     r_bitIdx;
    logic [8:0]     r_shift;
    logic           r_data9;
    logic           r_stop2;
    logic           r_stopIdx;
    logic           r_frameErr;
    logic           r_write;
    logic [8:0]     r_wbyte;
    logic           r_error;
    logic           r_timeout;
    logic [7:0]     r_idleCnt;
    logic           r_armed;

    logic           w_srstN;
    logic           w_rxs;
    logic           w_fall;
    logic [CKW-1:0] w_div;
    logic [CKW-1:0] w_mid;
    logic [CKW-1:0] w_last;
    logic           w_wrap;
    logic [3:0]     w_lastBit;
    logic           w_sampleNow;
    logic           w_sampleBit;
    logic           w_timeoutHit;

    // Reset and UART-disable share one path: either one clears everything,
    // including the synchronizer, so a half-received character is dropped.
    assign w_srstN = rst_n & clr_n;

    uart_rx_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rstN  (w_srstN),
        .i_async (rxd),
        .o_sync  (w_rxs),
        .o_fall  (w_fall)
    );

    // Bit-period arithmetic. The divider is floored at the minimum legal
    // value so that a misprogrammed register can never push the mid-bit
    // point (or the point after it) past the end of the period. The wrap
    // test uses >= so that shrinking ckdiv while idle cannot leave the
    // counter stranded above the new end value.
    assign w_div     = (ckdiv < DIV_FLOOR) ? DIV_FLOOR : ckdiv;
    assign w_mid     = w_div >> 1;
    assign w_last    = w_div - CNT_ONE;
    assign w_wrap    = (r_cnt >= w_last);
    assign w_lastBit = (r_data9 ? DATA_BITS_9 : DATA_BITS_8) - 4'd1;

    // The timeout fires on the bit-period boundary at which the count of
    // elapsed idle periods would reach the programmed value.
    assign w_timeoutHit = ({1'b0, r_idleCnt} + 9'd1) >= {1'b0, totime};

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] r_hist;

    // Two-deep history of the synchronized line. At the clock where the
    // counter sits one past mid-bit, r_hist holds the mid-1 and mid values
    // and w_rxs is the mid+1 value, so all three votes are available at once.
    always_ff @(posedge clk) begin
        if (!w_srstN) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rxs};
        end
    end

    assign w_sampleNow = (r_cnt == (w_mid + CNT_ONE));
    assign w_sampleBit = majority3(r_hist[1], r_hist[0], w_rxs);
`else
    assign w_sampleNow = (r_cnt == w_mid);
    assign w_sampleBit = w_rxs;
`endif

    // Receive state machine with all of its outputs registered.
    //
    // The bit counter free-runs through 0..ckdiv-1 in every state; only a
    // start edge seen in IDLE zeroes it. Because the start bit is judged at
    // mid-bit and the counter simply keeps counting, every later mid-bit
    // falls exactly one period after the previous one, giving the
    // phase-aligned restart without a separate reload.
    //
    // data9b and stop2b are captured when the start edge is accepted so a
    // register write in the middle of a frame only affects the next one.
    //
    // After the last stop sample the FSM is back in IDLE immediately, so a
    // start edge arriving in the second half of the stop bit is accepted.
    // The push decision (framing error, FIFO full) is made at that same
    // clock, which puts rf_write in the following cycle.
    //
    // The idle-period counter only runs once a character has been pushed
    // since the last timeout (r_armed), counts bit-period wraps while IDLE,
    // and is restarted by every start edge. A zero totime parks the counter
    // and keeps the timeout level low.
    always_ff @(posedge clk) begin
        if (!w_srstN) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bitIdx   <= '0;
            r_shift    <= '0;
            r_data9    <= 1'b0;
            r_stop2    <= 1'b0;
            r_stopIdx  <= 1'b0;
            r_frameErr <= 1'b0;
            r_write    <= 1'b0;
            r_wbyte    <= '0;
            r_error    <= 1'b0;
            r_timeout  <= 1'b0;
            r_idleCnt  <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_write <= 1'b0;

            if ((r_state == IDLE) && w_fall) begin
                r_cnt <= '0;
            end else if (w_wrap) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_ONE;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_state   <= START;
                        r_data9   <= data9b;
                        r_stop2   <= stop2b;
                        r_timeout <= 1'b0;
                        r_idleCnt <= '0;
                    end else if (totime == 8'd0) begin
                        r_timeout <= 1'b0;
                        r_idleCnt <= '0;
                    end else if (r_armed && w_wrap) begin
                        if (w_timeoutHit) begin
                            r_timeout <= 1'b1;
                            r_armed   <= 1'b0;
                            r_idleCnt <= '0;
                        end else begin
                            r_idleCnt <= r_idleCnt + 8'd1;
                        end
                    end
                end

                START: begin
                    if (w_sampleNow) begin
                        if (w_sampleBit) begin
                            r_state <= IDLE;
                        end else begin
                            r_state  <= DATA;
                            r_bitIdx <= '0;
                        end
                    end
                end

                DATA: begin
                    if (w_sampleNow) begin
                        if (r_data9) begin
                            r_shift <= {w_sampleBit, r_shift[8:1]};
                        end else begin
                            r_shift <= {1'b0, w_sampleBit, r_shift[7:1]};
                        end
                        if (r_bitIdx == w_lastBit) begin
                            r_state    <= STOP;
                            r_stopIdx  <= 1'b0;
                            r_frameErr <= 1'b0;
                        end else begin
                            r_bitIdx <= r_bitIdx + 4'd1;
                        end
                    end
                end

                STOP: begin
                    if (w_sampleNow) begin
                        if (r_stop2 && !r_stopIdx) begin
                            r_stopIdx  <= 1'b1;
                            r_frameErr <= ~w_sampleBit;
                        end else begin
                            r_state <= IDLE;
                            if (r_frameErr || !w_sampleBit || rf_full) begin
                                r_error <= 1'b1;
                            end else begin
                                r_write <= 1'b1;
                                r_wbyte <= r_shift;
                                r_armed <= 1'b1;
                            end
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign rf_write = r_write;
    assign rf_wbyte = r_wbyte;
    assign error    = r_error;
    assign timeout  = r_timeout;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. Frames are serialised onto rxd from a
// character value and frame options; the expected FIFO push (character and
// the clock at which it must appear) is queued when the frame starts, and a
// monitor compares every rf_write against the head of that queue. Error and
// timeout levels are compared against a small sticky-flag model.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CKW  = 24;
    localparam int SYNC = 2;

    logic           clk     = 1'b0;
    logic           rst_n   = 1'b0;
    logic           clr_n   = 1'b1;
    logic [CKW-1:0] ckdiv   = 24'd16;
    logic           data9b  = 1'b0;
    logic           stop2b  = 1'b0;
    logic [7:0]     totime  = 8'd0;
    logic           rxd     = 1'b1;
    logic           rf_full = 1'b0;
    logic           rf_write;
    logic [8:0]     rf_wbyte;
    logic           error;
    logic           timeout;

    typedef struct {
        logic [8:0] b;
        int         c;
    } exp_t;

    exp_t expQ[$];
    exp_t mon;
    int   cyc         = 0;
    int   nCompared   = 0;
    int   nMismatch   = 0;
    bit   errModel    = 1'b0;
    int   lastPushCyc = 0;

    uart_rx #(
        .CKW         (CKW),
        .SYNC_STAGES (SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_n    (clr_n),
        .ckdiv    (ckdiv),
        .data9b   (data9b),
        .stop2b   (stop2b),
        .totime   (totime),
        .rxd      (rxd),
        .rf_write (rf_write),
        .rf_wbyte (rf_wbyte),
        .rf_full  (rf_full),
        .error    (error),
        .timeout  (timeout)
    );

    // 100 MHz clock and a free-running count of rising edges.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        nCompared++;
        if (actual != expected) begin
            nMismatch++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkRange(input string name, input longint actual, input longint lo, input longint hi);
        nCompared++;
        if (actual < lo || actual > hi) begin
            nMismatch++;
            $display("[TB] FAIL %s: got %0d, expected %0d..%0d", name, actual, lo, hi);
        end
    endtask

    // Monitor: every push must match the oldest outstanding expectation in
    // both value and arrival clock.
    always @(negedge clk) begin
        if (rst_n && rf_write) begin
            checkOutput("push_was_expected", longint'(expQ.size() != 0), 1);
            if (expQ.size() != 0) begin
                mon = expQ.pop_front();
                checkOutput("rf_wbyte", rf_wbyte, mon.b);
                checkOutput("push_cycle", cyc, mon.c);
                lastPushCyc = cyc;
            end
        end
    end

    // Serialises one frame. rxd changes on falling clock edges and every bit
    // lasts ckdiv clocks. The start edge on rxd needs SYNC clocks to reach
    // the synchronized line and one more to be acted on; from there a push
    // takes (ckdiv>>1) + (N+S)*ckdiv + 1 clocks. badIdx selects a stop bit
    // driven low (-1 = none). aborted frames queue nothing and skip checks.
    task automatic applyStimulus(input logic [8:0] data, input bit nine, input bit two,
                                 input int badIdx, input bit full, input bit aborted);
        int   n;
        int   s;
        int   ck;
        int   c0;
        exp_t e;
        n  = nine ? 9 : 8;
        s  = two ? 2 : 1;
        ck = int'(ckdiv);
        @(negedge clk);
        data9b  = nine;
        stop2b  = two;
        rf_full = full;
        rxd     = 1'b0;
        c0      = cyc;
        if (!aborted) begin
            if (badIdx < 0 && !full) begin
                e.b = nine ? data : (data & 9'h0FF);
                e.c = c0 + SYNC + 1 + (ck >> 1) + (n + s) * ck + 1;
                expQ.push_back(e);
            end else begin
                errModel = 1'b1;
            end
        end
        repeat (ck) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            rxd = data[i];
            repeat (ck) @(negedge clk);
        end
        for (int i = 0; i < s; i++) begin
            rxd = (i == badIdx) ? 1'b0 : 1'b1;
            repeat (ck) @(negedge clk);
        end
        rxd = 1'b1;
        if (!aborted) begin
            repeat (2) @(negedge clk);
            checkOutput("error_flag", error, errModel);
        end
    endtask

    task automatic idleCycles(input int k);
        rxd = 1'b1;
        repeat (k) @(negedge clk);
    endtask

    task automatic pulseClear();
        @(negedge clk);
        clr_n = 1'b0;
        @(negedge clk);
        clr_n    = 1'b1;
        errModel = 1'b0;
    endtask

    // Hard stop in case something upstream never returns.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got cycle %0d, expected < 100000", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int  riseCyc;
        bit  seen;
        int  ck;
        int  bad;
        bit  nine;
        bit  two;
        bit  full;

        $display("[TB] uart_rx bench starting");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_rf_write", rf_write, 0);
        checkOutput("reset_rf_wbyte", rf_wbyte, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_timeout", timeout, 0);
        idleCycles(20);

        // 8N1 at the minimum divider, including exact push latency.
        ckdiv = 24'd16;
        applyStimulus(9'h0A5, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        idleCycles(10);

        // 9-bit, two stop bits; then a low second stop bit; error is sticky.
        applyStimulus(9'h1FF, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        idleCycles(8);
        applyStimulus(9'h0AA, 1'b1, 1'b1, 1, 1'b0, 1'b0);
        idleCycles(8);
        applyStimulus(9'h155, 1'b1, 1'b1, -1, 1'b0, 1'b0);
        idleCycles(8);
        pulseClear();
        @(negedge clk);
        checkOutput("error_cleared_by_clr", error, 0);
        idleCycles(8);

        // 4-clock glitch is a false start: no push, no error.
        @(negedge clk);
        rxd = 1'b0;
        repeat (4) @(negedge clk);
        rxd = 1'b1;
        idleCycles(40);
        checkOutput("glitch_no_error", error, 0);
        applyStimulus(9'h066, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        idleCycles(8);

        // Overrun against a full FIFO, then a normal push.
        applyStimulus(9'h03C, 1'b0, 1'b0, -1, 1'b1, 1'b0);
        idleCycles(8);
        applyStimulus(9'h03C, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        idleCycles(8);
        pulseClear();
        idleCycles(8);

        // Frame options flip mid-frame; the frame keeps its 9-bit 2-stop form.
        fork
            applyStimulus(9'h1A3, 1'b1, 1'b1, -1, 1'b0, 1'b0);
            begin
                repeat (40) @(negedge clk);
                data9b = 1'b0;
                stop2b = 1'b0;
            end
        join
        idleCycles(8);

        // Timeout after one character and four idle bit periods.
        totime = 8'd4;
        applyStimulus(9'h05A, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        riseCyc = -1;
        for (int k = 0; k < 200 && riseCyc < 0; k++) begin
            @(negedge clk);
            if (timeout) riseCyc = cyc;
        end
        checkOutput("timeout_rose", longint'(riseCyc >= 0), 1);
        if (riseCyc >= 0) begin
            checkRange("timeout_delay", riseCyc - lastPushCyc, 48, 80);
        end
        idleCycles(20);
        checkOutput("timeout_holds", timeout, 1);
        fork
            applyStimulus(9'h033, 1'b0, 1'b0, -1, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge clk);
                checkOutput("timeout_before_start", timeout, 1);
                repeat (2) @(negedge clk);
                checkOutput("timeout_cleared_by_start", timeout, 0);
            end
        join
        totime = 8'd0;
        seen   = 1'b0;
        repeat (200) begin
            @(negedge clk);
            if (timeout) seen = 1'b1;
        end
        checkOutput("timeout_disabled", seen, 0);

        // Clear pulse late in the last data bit of 0x55 drops the frame; the
        // re-synchronised low line then fails as a false start on the stop bit.
        pulseClear();
        idleCycles(8);
        fork
            applyStimulus(9'h055, 1'b0, 1'b0, -1, 1'b0, 1'b1);
            begin
                repeat (138) @(negedge clk);
                clr_n = 1'b0;
                @(negedge clk);
                clr_n    = 1'b1;
                errModel = 1'b0;
            end
        join
        idleCycles(20);
        checkOutput("clr_mid_frame_error", error, 0);
        applyStimulus(9'h081, 1'b0, 1'b0, -1, 1'b0, 1'b0);
        idleCycles(8);

        // Randomised frames across dividers, widths, stop counts and faults.
        for (int f = 0; f < 24; f++) begin
            ck    = int'($urandom_range(24, 16));
            ckdiv = CKW'(ck);
            nine  = 1'($urandom_range(1, 0));
            two   = 1'($urandom_range(1, 0));
            full  = ($urandom_range(5, 0) == 0);
            bad   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(two ? 1 : 0, 0)) : -1;
            applyStimulus(9'($urandom_range(511, 0)), nine, two, bad, full, 1'b0);
            idleCycles(int'($urandom_range(20, 4)));
            if ($urandom_range(4, 0) == 0) begin
                pulseClear();
                @(negedge clk);
                checkOutput("random_clr_error", error, 0);
            end
        end
        rf_full = 1'b0;

        idleCycles(50);
        checkOutput("scoreboard_drained", expQ.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
